// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues in-order 32-bit reads ahead of decode and
// buffers {pc, instr} pairs in a small FIFO; redirects flush and drop stale responses.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [63:0]            imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic [31:0]            ir_instr,
  output logic [63:0]            ir_pc,
  input  logic                   redirect,
  input  logic [63:0]            redirect_pc,
  input  logic                   halt,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [63:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic [CW:0]   in_use;
  logic          has_credit;
  logic          issue;
  logic          pop;
  logic          rsp_tracked;
  logic          discard;
  logic          keep;
  logic          push;
  logic [63:0]   redirect_aligned;

  // Every buffered entry, kept request and doomed request holds one credit.
  assign in_use     = {1'b0, count_q} + {1'b0, outst_q} + {1'b0, drop_q};
  assign has_credit = in_use < (CW+1)'(DEPTH);

  assign imem_req  = reset && !halt && !redirect && has_credit;
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req && imem_gnt;

  assign ir_valid  = reset && (count_q != '0);
  assign ir_instr  = ir_valid ? instr_mem_q[head_q] : '0;
  assign ir_pc     = ir_valid ? pc_mem_q[head_q] : '0;
  assign occupancy = count_q;
  assign pop       = ir_valid && ir_ready;

  // Responses we never asked for (nothing in flight) are ignored outright.
  assign rsp_tracked = imem_rvalid && ((outst_q != '0) || (drop_q != '0));
  assign discard     = imem_rvalid && (drop_q != '0);
  assign keep        = imem_rvalid && (drop_q == '0) && (outst_q != '0);
  assign push        = keep && !redirect;

  assign redirect_aligned = redirect_pc & ~64'h3;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (redirect) begin
      // Everything still in flight becomes stale, minus the one landing now.
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      count_d    = '0;
      outst_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = drop_q + outst_q - CW'(rsp_tracked);
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 64'd4;
        tail_d    = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      outst_d = outst_q + CW'(issue) - CW'(keep);
      drop_d  = drop_q - CW'(discard);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Storage needs no reset: outputs are gated by ir_valid.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      pc_mem_q[tail_q]    <= resp_pc_q;
      instr_mem_q[tail_q] <= imem_rdata;
    end
  end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch stage that sits directly upstream of the `tinker_core` decode/IR capture. It issues in-order 32-bit instruction reads to the instruction memory port and buffers the returned words with their PCs in a small FIFO. It hands them to the core over a valid/ready interface. Control-flow redirects (jump, branch, call, return) flush the buffer and restart fetch at the new PC; responses still in flight from before the redirect are dropped.

## Interface

Parameters:
- DEPTH, 4 — FIFO entries and maximum in-flight requests; power of two, 2..16.
- RESET_PC, 64'h2000 — first fetch address after reset.

Ports:
- clk  in  1  — clock, all state updates on rising edge.
- reset  in  1  — one clock; reset is synchronous and active-low; asserted when 0, sampled on the rising edge of clk.
- imem_req  out  1  — read request valid (combinational from state).
- imem_addr  out  64  — byte address of the request; equals fetch_pc.
- imem_gnt  in  1  — request accepted this cycle (req && gnt = issue).
- imem_rvalid  in  1  — response valid. Responses arrive in issue order, at least 1 cycle after the issue.
- imem_rdata  in  32  — instruction word, valid with imem_rvalid.
- ir_valid  out  1  — buffered instruction available.
- ir_ready  in  1  — core accepts the head entry (ir_valid && ir_ready = pop).
- ir_instr  out  32  — head instruction word.
- ir_pc  out  64  — PC of the head instruction.
- redirect  in  1  — flush and restart fetch at redirect_pc.
- redirect_pc  in  64  — new fetch PC; bits [1:0] are ignored and treated as 0.
- halt  in  1  — level; stops issuing new requests (core hlt).
- occupancy  out  $clog2(DEPTH)+1  — current FIFO entry count.

## Operation

- State: fetch_pc (next address to issue), resp_pc (PC tag of the next non-dropped response), count (FIFO entries), outstanding (issued, not yet returned, to be kept), drop_cnt (in flight, to be discarded), DEPTH-entry FIFO of {pc, instr} with head/tail pointers that wrap modulo DEPTH.
- Issue rule: imem_req = reset && !halt && !redirect && (count + outstanding + drop_cnt < DEPTH).
  - On issue, fetch_pc <= fetch_pc + 4 (64-bit wrap) and outstanding++.
- Response, drop_cnt > 0: discard the data; drop_cnt--.
- Response, drop_cnt == 0: push {resp_pc, imem_rdata} at the tail; resp_pc += 4; outstanding--.
- Pop: on ir_valid && ir_ready, advance the head; count--.
- ir_valid = (count != 0). ir_instr and ir_pc come from the head entry.
- Simultaneous push and pop: count is unchanged and both pointers advance. Overflow is impossible by the credit rule. A push when count == DEPTH is an assertion failure in verification.
- Redirect (highest priority) takes effect at the next edge:
  - count <= 0; head and tail <= 0; outstanding <= 0.
  - drop_cnt <= drop_cnt + outstanding − (imem_rvalid ? 1 : 0).
  - fetch_pc <= resp_pc <= {redirect_pc[63:2], 2'b00}.
  - A response arriving in the redirect cycle is discarded. A pop in the redirect cycle completes, but the flush discards the rest.
- Halt: no new issues. Outstanding responses are still captured, and the FIFO still drains to the core. Deasserting halt resumes issuing at fetch_pc.
- Redirect during halt: the flush and PC update still occur; no issue happens until halt drops.
- Reset (reset == 0 at an edge), including mid-operation:
  - fetch_pc = resp_pc = RESET_PC.
  - count, outstanding, drop_cnt, pointers = 0.
  - While reset is asserted, imem_req = 0 and ir_valid = 0. Responses arriving during reset are ignored.

## Timing

- Reset values: imem_req 0, imem_addr RESET_PC, ir_valid 0, ir_instr/ir_pc don't-care (implementation zeroes them), occupancy 0.
- Minimum latency: issue at cycle N, rvalid at N+1, ir_valid at N+2. With 1-cycle memory and ir_ready held 1, the steady state is one instruction per cycle.
- Redirect asserted at cycle R: imem_req is 0 in cycle R. The first new request is at R+1 with imem_addr = redirect_pc, provided credits allow (drop_cnt counts against credit). ir_valid is 0 in R+1.
- No combinational path from ir_ready to ir_valid. imem_req depends combinationally only on registered state, halt, redirect and reset.

## Test plan

- Reset release, 1-cycle memory returning addr-derived data, ir_ready = 1 → addresses 0x2000, 0x2004, 0x2008…. First ir_valid 2 cycles after the first issue with ir_pc = 0x2000, then one pop per cycle with consecutive PCs.
- ir_ready = 0 with memory always granting → exactly DEPTH (4) issues. imem_req drops, occupancy = 4 and holds. Raising ir_ready pops 0x2000 first, and issue resumes one cycle after the first pop.
- Memory latency 3 with 3 requests in flight, redirect to 0x3000 → occupancy 0 next cycle. The 3 stale responses are discarded. The first delivered ir_pc = 0x3000, carrying the data returned for the 0x3000 request.
- Redirect in the same cycle as an rvalid and a pop → the pop completes, the response is dropped, drop_cnt = outstanding − 1, and no stale PC ever appears on ir_pc.
- Halt asserted mid-stream with 2 in flight → no new requests, both responses delivered, occupancy drains to 0. Releasing halt resumes at the next sequential PC.
- Reset (reset = 0) asserted mid-operation with a full FIFO → next cycle ir_valid = 0, occupancy = 0, imem_addr = 0x2000. Late responses arriving during reset are ignored.
